cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits between the cache's physical-memory side (pmem_read/pmem_write/pmem_resp) and the burst DRAM model.
- Converts one 256-bit cache line transaction into four 64-bit burst beats, and back.
- Latches the line-aligned address and any write data at request time.
- Collects read beats into a line buffer and returns a single-cycle response to the cache.

Parameters:
LINE_WIDTH, 256, cache line width in bits
BURST_WIDTH, 64, DRAM beat width in bits
ADDR_WIDTH, 32, byte address width
(derived) BEATS = LINE_WIDTH/BURST_WIDTH = 4; OFFSET_BITS = log2(LINE_WIDTH/8) = 5

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
address_i  in  ADDR_WIDTH  cache-side line address
read_i  in  1  cache line read request (pmem_read)
write_i  in  1  cache line write request (pmem_write)
line_i  in  LINE_WIDTH  line to write back
line_o  out  LINE_WIDTH  assembled read line
resp_o  out  1  transaction complete (pmem_resp), 1-cycle pulse
address_o  out  ADDR_WIDTH  DRAM burst address, line-aligned
read_o  out  1  DRAM burst read
write_o  out  1  DRAM burst write
burst_o  out  BURST_WIDTH  write beat data
burst_i  in  BURST_WIDTH  read beat data
resp_i  in  1  DRAM beat valid/accepted

Behaviour:
- States: IDLE, READ, WRITE, DONE. Beat counter cnt is 2 bits. Registers: addr_q, buf_q[BEATS].
- Reset:
  - state=IDLE, cnt=0, addr_q=0, buf_q=0.
  - read_o, write_o, resp_o=0; address_o=0; burst_o=0; line_o=0.
- IDLE, write_i=1:
  - Latch addr_q={address_i[ADDR_WIDTH-1:5],5'b0}.
  - Latch buf_q=line_i (beat k = line_i[64k+63:64k]).
  - cnt=0; next state WRITE.
- IDLE, read_i=1 and write_i=0: latch addr_q; cnt=0; next state READ.
- IDLE, read_i=1 and write_i=1: write wins.
- READ:
  - read_o=1, address_o=addr_q.
  - Each cycle with resp_i=1: buf_q[cnt]<=burst_i, cnt++.
  - On resp_i with cnt==3: next state DONE.
  - resp_i=0 cycles are stalls; state and cnt hold.
- WRITE:
  - write_o=1, address_o=addr_q, burst_o=buf_q[cnt] (combinational from cnt).
  - resp_i=1 means beat cnt accepted; cnt++.
  - On resp_i with cnt==3: next state DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0.
  - line_o=concatenation of buf_q (beat 0 in LSBs); next state IDLE.
- line_o is driven from buf_q at all times; it is valid only while resp_o=1.
- Requests arriving outside IDLE are ignored. The cache holds its request until resp_o.
- A request still high in the cycle after DONE starts a new transaction.
- Minimum latency is 6 cycles from request to resp_o: 1 latch, 4 beats, 1 DONE.
- address_i and line_i changes after the latch have no effect.
- rst asserted mid-burst aborts at the next edge: IDLE, all outputs 0, no resp_o.
- resp_i while in IDLE or DONE is ignored.
- cnt wraps to 0 on the 4th beat.

Optional Feature:
- Macro ADAPTOR_PERF_EN.
- When defined, three extra outputs, each 32 bits:
  - rd_cnt_o: completed reads.
  - wr_cnt_o: completed writes.
  - stall_cnt_o: READ/WRITE cycles with resp_i=0.
- Counters saturate at all-ones and reset to 0 on rst.
- rd_cnt_o/wr_cnt_o increment in the DONE cycle, according to which transaction was served.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cacheline_pkg holds:
  - LINE_WIDTH, BURST_WIDTH, ADDR_WIDTH, BEATS, OFFSET_BITS.
  - typedef adaptor_state_t {IDLE, READ, WRITE, DONE}.
  - typedef line_t and beat_t.
- No sub-module; the FSM, counter and buffer live in one module.

Test Plan:
- Read, no stalls: read_i=1, address_i=0x1234_5678 -> address_o=0x1234_5660. Beats 0x11..,0x22..,0x33..,0x44.. on 4 consecutive resp_i -> resp_o pulses one cycle later. line_o={0x44..,0x33..,0x22..,0x11..}.
- Write: line_i=256'h{D,C,B,A} beats, resp_i held high -> burst_o=A,B,C,D on successive cycles, write_o high 4 cycles, then resp_o=1 for 1 cycle.
- Stalls: read with resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order. resp_o follows the 7th cycle. stall_cnt_o=3 with ADAPTOR_PERF_EN.
- Simultaneous read_i=write_i=1 in IDLE -> write burst performed first. Read_i still high after resp_o -> read burst follows.
- rst=1 after 2 write beats -> next cycle write_o=0, resp_o=0, state IDLE. A new read then completes correctly with cnt starting at 0.
- Back-to-back: write then read to same line -> read returns data supplied on burst_i, not stale buf_q contents.

Source files
------------

// File: rtl/cacheline_pkg.sv
// cacheline_pkg: shared widths, derived constants and types for the
// cache-line-to-DRAM-burst adaptor.
//   LINE_WIDTH  : cache line width in bits
//   BURST_WIDTH : DRAM beat width in bits
//   ADDR_WIDTH  : byte address width
//   BEATS       : beats per line
//   OFFSET_BITS : byte-offset bits within a line
package cacheline_pkg;

   localparam int unsigned LINE_WIDTH  = 256;
   localparam int unsigned BURST_WIDTH = 64;
   localparam int unsigned ADDR_WIDTH  = 32;
   localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
   localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);
   localparam int unsigned CNT_WIDTH   = $clog2(BEATS);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } adaptor_state_t;

   typedef logic [LINE_WIDTH-1:0]  line_t;
   typedef logic [BURST_WIDTH-1:0] beat_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts one cache line transaction into a burst of
// BEATS DRAM beats (write) or collects BEATS beats into a line (read), then
// pulses resp_o for one cycle.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   address_i             : cache-side line address
//   read_i / write_i      : cache line read / write request (write wins)
//   line_i / line_o       : line to write back / assembled read line
//   resp_o                : one-cycle transaction-complete pulse
//   address_o             : line-aligned DRAM burst address
//   read_o / write_o      : DRAM burst read / write
//   burst_o / burst_i     : write beat data / read beat data
//   resp_i                : DRAM beat valid/accepted
// Optional (macro ADAPTOR_PERF_EN):
//   rd_cnt_o, wr_cnt_o    : completed reads / writes (saturating)
//   stall_cnt_o           : burst cycles with resp_i low (saturating)
module cacheline_adaptor
   import cacheline_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] address_i,
   input  logic                  read_i,
   input  logic                  write_i,
   input  line_t                 line_i,
   output line_t                 line_o,
   output logic                  resp_o,
   output logic [ADDR_WIDTH-1:0] address_o,
   output logic                  read_o,
   output logic                  write_o,
   output beat_t                 burst_o,
   input  beat_t                 burst_i,
   input  logic                  resp_i
`ifdef ADAPTOR_PERF_EN
   ,
   output logic [31:0]           rd_cnt_o,
   output logic [31:0]           wr_cnt_o,
   output logic [31:0]           stall_cnt_o
`endif
);

   adaptor_state_t                        state_q, state_d;
   logic [CNT_WIDTH-1:0]                  cnt_q;
   logic [ADDR_WIDTH-1:0]                 addr_q;
   logic [BEATS-1:0][BURST_WIDTH-1:0]     buf_q;

   // Byte-offset bits are discarded by line alignment.
   logic unused_offset;
   assign unused_offset = ^address_i[OFFSET_BITS-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (write_i || read_i) begin
                  addr_q <= {address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                  cnt_q  <= '0;
               end
               if (write_i) buf_q <= line_i;
            end
            READ: begin
               if (resp_i) begin
                  buf_q[cnt_q] <= burst_i;
                  cnt_q        <= cnt_q + 1'b1;
               end
            end
            WRITE: begin
               if (resp_i) cnt_q <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      read_o    = 1'b0;
      write_o   = 1'b0;
      resp_o    = 1'b0;
      address_o = '0;
      burst_o   = '0;
      unique case (state_q)
         IDLE: begin
            if (write_i)     state_d = WRITE;
            else if (read_i) state_d = READ;
         end
         READ: begin
            read_o    = 1'b1;
            address_o = addr_q;
            if (resp_i && cnt_q == CNT_WIDTH'(BEATS - 1)) state_d = DONE;
         end
         WRITE: begin
            write_o   = 1'b1;
            address_o = addr_q;
            burst_o   = buf_q[cnt_q];
            if (resp_i && cnt_q == CNT_WIDTH'(BEATS - 1)) state_d = DONE;
         end
         DONE: begin
            resp_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Packed buffer: beat 0 occupies the line's least significant bits.
   assign line_o = buf_q;

`ifdef ADAPTOR_PERF_EN
   // Remembers which kind of transaction DONE is completing.
   logic        served_wr_q;
   logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         served_wr_q <= 1'b0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (state_q == IDLE && (write_i || read_i)) served_wr_q <= write_i;
         if (state_q == DONE) begin
            if (served_wr_q) begin
               if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
               if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
            end
         end
         if ((state_q == READ || state_q == WRITE) && !resp_i) begin
            if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign rd_cnt_o    = rd_cnt_q;
   assign wr_cnt_o    = wr_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: self-checking bench for cacheline_adaptor. A
// behavioural model records the beats handed over per transaction and the
// expected perf counts; DUT outputs are sampled on the falling clock edge.
module tb_cacheline_adaptor;
   import cacheline_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [ADDR_WIDTH-1:0] address_i;
   logic                  read_i, write_i;
   line_t                 line_i, line_o;
   logic                  resp_o;
   logic [ADDR_WIDTH-1:0] address_o;
   logic                  read_o, write_o;
   beat_t                 burst_o, burst_i;
   logic                  resp_i;
`ifdef ADAPTOR_PERF_EN
   logic [31:0]           rd_cnt_o, wr_cnt_o, stall_cnt_o;
   int                    exp_rd, exp_wr, exp_stall;
`endif

   int errors = 0;
   int checks = 0;

   cacheline_adaptor dut (
      .clk       (clk),
      .rst       (rst),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .line_i    (line_i),
      .line_o    (line_o),
      .resp_o    (resp_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .burst_o   (burst_o),
      .burst_i   (burst_i),
      .resp_i    (resp_i)
`ifdef ADAPTOR_PERF_EN
      ,
      .rd_cnt_o    (rd_cnt_o),
      .wr_cnt_o    (wr_cnt_o),
      .stall_cnt_o (stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   function automatic line_t rand_line();
      line_t l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   // Runs one cache transaction starting from IDLE at a falling edge.
   // pat_len > 0 uses pat[cycle] as the resp_i pattern, else random stalls.
   task automatic run_txn(input bit wr, input bit rd_too, input logic [31:0] addr,
                          input line_t wline, input logic [15:0] pat, input int pat_len,
                          input bit keep_read, input string name);
      logic [31:0] exp_addr;
      beat_t       rbeats[4];
      line_t       exp_line;
      int          got, cyc;
      bit          r;
      exp_addr  = addr & ~32'h1f;
      write_i   = wr;
      read_i    = rd_too | ~wr;
      address_i = addr;
      line_i    = wline;
      resp_i    = 1'b0;
      @(posedge clk); @(negedge clk);
      // Changes after the latch must not matter.
      address_i = $urandom;
      line_i    = rand_line();
      got = 0;
      cyc = 0;
      while (got < 4 && cyc < 200) begin
         checks++;
         if (read_o !== ~wr || write_o !== wr || resp_o !== 1'b0) begin
            errors++;
            $display("FAIL %s strobes cyc%0d: read_o=%b write_o=%b resp_o=%b expected %b %b 0",
                     name, cyc, read_o, write_o, resp_o, ~wr, wr);
         end
         checks++;
         if (address_o !== exp_addr) begin
            errors++;
            $display("FAIL %s address_o: got %h expected %h", name, address_o, exp_addr);
         end
         if (wr) begin
            checks++;
            if (burst_o !== wline[64*got +: 64]) begin
               errors++;
               $display("FAIL %s burst_o beat%0d: got %h expected %h",
                        name, got, burst_o, wline[64*got +: 64]);
            end
         end
         if (pat_len > 0) r = (cyc < pat_len) ? pat[cyc] : 1'b1;
         else             r = ($urandom_range(0, 3) != 0);
         resp_i  = r;
         burst_i = {$urandom, $urandom};
         if (r) begin
            rbeats[got] = burst_i;
            got++;
         end else begin
`ifdef ADAPTOR_PERF_EN
            exp_stall++;
`endif
         end
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      if (pat_len > 0) begin
         checks++;
         if (cyc != pat_len) begin
            errors++;
            $display("FAIL %s burst length: got %0d cycles expected %0d", name, cyc, pat_len);
         end
      end
      // DONE cycle: resp_i here must be ignored.
      resp_i = $urandom_range(0, 1);
      checks++;
      if (resp_o !== 1'b1 || read_o !== 1'b0 || write_o !== 1'b0) begin
         errors++;
         $display("FAIL %s done: resp_o=%b read_o=%b write_o=%b expected 1 0 0",
                  name, resp_o, read_o, write_o);
      end
      if (!wr) begin
         for (int k = 0; k < 4; k++) exp_line[64*k +: 64] = rbeats[k];
         checks++;
         if (line_o !== exp_line) begin
            errors++;
            $display("FAIL %s line_o: got %h expected %h", name, line_o, exp_line);
         end
      end
`ifdef ADAPTOR_PERF_EN
      if (wr) exp_wr++;
      else    exp_rd++;
`endif
      write_i = 1'b0;
      read_i  = keep_read;
      @(posedge clk); @(negedge clk);
      resp_i = 1'b0;
      checks++;
      if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || address_o !== '0) begin
         errors++;
         $display("FAIL %s idle: resp_o=%b read_o=%b write_o=%b address_o=%h expected 0",
                  name, resp_o, read_o, write_o, address_o);
      end
`ifdef ADAPTOR_PERF_EN
      checks++;
      if (rd_cnt_o !== exp_rd || wr_cnt_o !== exp_wr || stall_cnt_o !== exp_stall) begin
         errors++;
         $display("FAIL %s perf: rd=%0d wr=%0d stall=%0d expected %0d %0d %0d",
                  name, rd_cnt_o, wr_cnt_o, stall_cnt_o, exp_rd, exp_wr, exp_stall);
      end
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      read_i = 1'b0; write_i = 1'b0; resp_i = 1'b1;
      address_i = 32'hffff_ffff; line_i = rand_line(); burst_i = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 ||
          address_o !== '0 || burst_o !== '0 || line_o !== '0) begin
         errors++;
         $display("FAIL reset: read_o=%b write_o=%b resp_o=%b address_o=%h burst_o=%h line_o=%h expected all 0",
                  read_o, write_o, resp_o, address_o, burst_o, line_o);
      end
`ifdef ADAPTOR_PERF_EN
      exp_rd = 0; exp_wr = 0; exp_stall = 0;
      checks++;
      if (rd_cnt_o !== 0 || wr_cnt_o !== 0 || stall_cnt_o !== 0) begin
         errors++;
         $display("FAIL reset perf: rd=%0d wr=%0d stall=%0d expected 0", rd_cnt_o, wr_cnt_o, stall_cnt_o);
      end
`endif
      rst = 1'b0;
      resp_i = 1'b0;
      // resp_i in IDLE is ignored.
      resp_i = 1'b1;
      @(posedge clk); @(negedge clk);
      resp_i = 1'b0;
      checks++;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_resp_i: read_o=%b write_o=%b resp_o=%b expected 0", read_o, write_o, resp_o);
      end
   endtask

   task automatic test_read_basic();
      run_txn(1'b0, 1'b0, 32'h1234_5678, '0, 16'h000f, 4, 1'b0, "read_basic");
   endtask

   task automatic test_write();
      line_t l;
      l = {64'hdddd_dddd_dddd_dddd, 64'hcccc_cccc_cccc_cccc,
           64'hbbbb_bbbb_bbbb_bbbb, 64'haaaa_aaaa_aaaa_aaaa};
      run_txn(1'b1, 1'b0, 32'h8000_003f, l, 16'h000f, 4, 1'b0, "write");
   endtask

   task automatic test_stalls();
      // resp_i pattern 1,0,0,1,1,0,1
      run_txn(1'b0, 1'b0, 32'hdead_beef, '0, 16'b1011001, 7, 1'b0, "stalls");
   endtask

   task automatic test_simultaneous();
      logic [31:0] a;
      a = $urandom;
      run_txn(1'b1, 1'b1, a, rand_line(), '0, 0, 1'b1, "simul_write");
      run_txn(1'b0, 1'b0, a, '0, '0, 0, 1'b0, "simul_read");
   endtask

   task automatic test_abort();
      line_t l;
      l = rand_line();
      write_i = 1'b1; address_i = 32'h0000_1040; line_i = l; resp_i = 1'b0;
      @(posedge clk); @(negedge clk);
      resp_i = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (write_o !== 1'b1 || burst_o !== l[127:64]) begin
         errors++;
         $display("FAIL abort beat1: write_o=%b burst_o=%h expected 1 %h", write_o, burst_o, l[127:64]);
      end
      @(posedge clk); @(negedge clk);
      rst = 1'b1; write_i = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (write_o !== 1'b0 || read_o !== 1'b0 || resp_o !== 1'b0 ||
          address_o !== '0 || burst_o !== '0 || line_o !== '0) begin
         errors++;
         $display("FAIL abort: write_o=%b read_o=%b resp_o=%b address_o=%h burst_o=%h line_o=%h expected all 0",
                  write_o, read_o, resp_o, address_o, burst_o, line_o);
      end
`ifdef ADAPTOR_PERF_EN
      exp_rd = 0; exp_wr = 0; exp_stall = 0;
`endif
      rst = 1'b0; resp_i = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (resp_o !== 1'b0 || write_o !== 1'b0) begin
         errors++;
         $display("FAIL abort no_resp: resp_o=%b write_o=%b expected 0 0", resp_o, write_o);
      end
      run_txn(1'b0, 1'b0, 32'h0000_1040, '0, 16'h000f, 4, 1'b0, "abort_read");
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      a = $urandom;
      run_txn(1'b1, 1'b0, a, rand_line(), '0, 0, 1'b0, "b2b_write");
      run_txn(1'b0, 1'b0, a, '0, '0, 0, 1'b0, "b2b_read");
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         run_txn($urandom_range(0, 1), $urandom_range(0, 1), $urandom, rand_line(),
                 '0, 0, 1'b0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write();
      test_stalls();
      test_simultaneous();
      test_abort();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
